shift_scan_ctrl: RTL

//  Sequences the six-lane serial shift-register outputs (SH1..SH6) of the user IP, plus
//  the common shift clock and the ST1 latch strobe. Holds two banks of frame data (ping-pong).
//  One bank is written by the host-side write port while the other is shifted out. At each

---
 rtl/shift_scan_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/shift_scan_ctrl.sv
// shift_scan_ctrl: six-lane serial shifter (shift clock, data, latch strobe) fed from a
// ping-pong frame store; the host fills the back bank and a commit swaps at a frame boundary.
module shift_scan_ctrl #(
   parameter  int NBITS  = 16,
   parameter  int CLKDIV = 4,
   localparam int AW     = $clog2(NBITS)
) (
   input  logic          sys_clock,
   input  logic          resetn,
   input  logic          enable,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [5:0]    wr_data,
   input  logic          commit,
   output logic          commit_pend,
   output logic          busy,
   output logic          sh_ck,
   output logic [5:0]    sh_dat,
   output logic          st,
   output logic          frame_done
);

   localparam int CW = $clog2(2 * CLKDIV + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
   localparam logic [CW-1:0] LAT_LAST = CW'(2 * CLKDIV - 1);
   localparam logic [AW-1:0] K_MSB    = AW'(NBITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LATCH,
      S_END
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   k_q, k_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            act_q, act_d;
   logic            pend_q, pend_d;
   logic            swap;
   logic            addr_ok;
   logic [5:0]      bank_q [2][NBITS];

   logic            sh_ck_q, sh_ck_d;
   logic            st_q, st_d;
   logic            fd_q, fd_d;
   logic            busy_q, busy_d;
   logic [5:0]      sh_dat_q, sh_dat_d;

   if ((1 << AW) == NBITS) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (int'(wr_addr) < NBITS);
   end

   // State register
   always_ff @(posedge sys_clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         act_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
      end
   end

   // A commit seen while nothing is pending (even on the END cycle) only arms the swap;
   // the swap itself is driven solely by the registered pending flag.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      pend_d  = pend_q | commit;
      swap    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_SHIFT_LO;
               k_d     = K_MSB;
               cnt_d   = '0;
               swap    = pend_q;
            end
         end
         S_SHIFT_LO: begin
            if (cnt_q == DIV_LAST) begin
               state_d = S_SHIFT_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT_HI: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (k_q == '0) begin
                  state_d = S_LATCH;
               end else begin
                  k_d     = k_q - 1'b1;
                  state_d = S_SHIFT_LO;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (cnt_q == LAT_LAST) begin
               state_d = S_END;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_END: begin
            swap = pend_q;
            if (enable) begin
               state_d = S_SHIFT_LO;
               k_d     = K_MSB;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (swap) begin
         act_d  = ~act_q;
         pend_d = 1'b0;
      end
   end

   // Outputs are decoded from the next state so the registered pins line up with state_q.
   always_comb begin
      sh_ck_d  = (state_d == S_SHIFT_HI);
      st_d     = (state_d == S_LATCH);
      fd_d     = (state_d == S_END);
      busy_d   = (state_d != S_IDLE);
      sh_dat_d = '0;
      if (state_d == S_SHIFT_LO || state_d == S_SHIFT_HI || state_d == S_LATCH) begin
         sh_dat_d = bank_q[act_d][k_d];
      end
   end

   always_ff @(posedge sys_clock or negedge resetn) begin
      if (!resetn) begin
         sh_ck_q  <= 1'b0;
         st_q     <= 1'b0;
         fd_q     <= 1'b0;
         busy_q   <= 1'b0;
         sh_dat_q <= '0;
      end else begin
         sh_ck_q  <= sh_ck_d;
         st_q     <= st_d;
         fd_q     <= fd_d;
         busy_q   <= busy_d;
         sh_dat_q <= sh_dat_d;
      end
   end

   // Writes use the pre-swap back bank; they are dropped whenever a commit is pending.
   always_ff @(posedge sys_clock or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned i = 0; i < NBITS; i++) begin
               bank_q[b][i] <= '0;
            end
         end
      end else if (wr_en && !pend_q && addr_ok) begin
         bank_q[~act_q][wr_addr] <= wr_data;
      end
   end

   assign commit_pend = pend_q;
   assign busy        = busy_q;
   assign sh_ck       = sh_ck_q;
   assign sh_dat      = sh_dat_q;
   assign st          = st_q;
   assign frame_done  = fd_q;

endmodule
